// File: rtl/m_dmem_ctrl.sv
// M-stage data-memory controller: request/grant/response handshake with store and load formatting.
// Optional MEM_EXC_EN flags misaligned loads/stores (adel_m/ades_m) instead of issuing them.
module m_dmem_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_rd_m,
    input  logic              mem_wr_m,
    input  logic [ADDR_W-1:0] addr_m,
    input  logic [31:0]       wdata_m,
    input  logic [1:0]        size_m,
    input  logic              sign_m,
    output logic              stall_m,
    output logic [31:0]       rdata_m,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [3:0]        dm_byteen,
    output logic [31:0]       dm_wdata,
    input  logic              dm_gnt,
    input  logic              dm_rvalid,
    input  logic [31:0]       dm_rdata,
    output logic              adel_m,
    output logic              ades_m
);

    // state | meaning
    // IDLE  | no access in flight; latch request when acc
    // REQ   | dm_req high, waiting for dm_gnt
    // WAIT  | load granted, waiting for dm_rvalid
    // DONE  | access complete, stall released for one cycle
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state;
    logic        misaligned;
    logic        acc;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        sign_q;
    logic [1:0]  off_nxt;
    logic [3:0]  byteen_nxt;
    logic [31:0] wdata_nxt;
    logic [31:0] shifted;
    logic [31:0] load_fmt;

`ifdef MEM_EXC_EN
    always_comb begin
        misaligned = 1'b0;
        case (size_m)
            2'b01:   misaligned = addr_m[0];
            2'b10:   misaligned = 1'b0;
            default: misaligned = |addr_m[1:0];
        endcase
    end
    assign adel_m = (state == IDLE) & mem_rd_m & misaligned;
    assign ades_m = (state == IDLE) & mem_wr_m & misaligned;
`else
    assign misaligned = 1'b0;
    assign adel_m     = 1'b0;
    assign ades_m     = 1'b0;
`endif

    assign acc     = (mem_rd_m | mem_wr_m) & ~misaligned;
    assign stall_m = acc & (state != DONE);

    // Halves ignore addr[0] and words ignore addr[1:0] when not trapping misalignment.
    always_comb begin
        off_nxt    = 2'b00;
        byteen_nxt = 4'b1111;
        wdata_nxt  = wdata_m;
        case (size_m)
            2'b01: begin
                off_nxt    = {addr_m[1], 1'b0};
                byteen_nxt = addr_m[1] ? 4'b1100 : 4'b0011;
                wdata_nxt  = {2{wdata_m[15:0]}};
            end
            2'b10: begin
                off_nxt    = addr_m[1:0];
                byteen_nxt = 4'b0001 << addr_m[1:0];
                wdata_nxt  = {4{wdata_m[7:0]}};
            end
            default: ;
        endcase
    end

    assign shifted = dm_rdata >> {off_q, 3'b000};

    always_comb begin
        case (size_q)
            2'b01:   load_fmt = {{16{sign_q & shifted[15]}}, shifted[15:0]};
            2'b10:   load_fmt = {{24{sign_q & shifted[7]}}, shifted[7:0]};
            default: load_fmt = shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            dm_req    <= 1'b0;
            dm_we     <= 1'b0;
            dm_addr   <= '0;
            dm_byteen <= 4'b0000;
            dm_wdata  <= 32'h0;
            rdata_m   <= 32'h0;
            off_q     <= 2'b00;
            size_q    <= 2'b00;
            sign_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (acc) begin
                        dm_req    <= 1'b1;
                        dm_we     <= mem_wr_m;
                        dm_addr   <= {addr_m[ADDR_W-1:2], 2'b00};
                        dm_byteen <= byteen_nxt;
                        dm_wdata  <= wdata_nxt;
                        off_q     <= off_nxt;
                        size_q    <= size_m;
                        sign_q    <= sign_m;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (dm_gnt) begin
                        dm_req <= 1'b0;
                        if (dm_we) begin
                            state <= DONE;
                        end else if (dm_rvalid) begin
                            rdata_m <= load_fmt;
                            state   <= DONE;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dm_rvalid) begin
                        rdata_m <= load_fmt;
                        state   <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_m_dmem_ctrl.sv
// Self-checking bench for m_dmem_ctrl: directed vector table, randomized accesses against a
// byte-lane reference model, reset-in-WAIT sequence and (with MEM_EXC_EN) a misaligned load.
module tb_m_dmem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_rd_m, mem_wr_m;
    logic [31:0] addr_m, wdata_m;
    logic [1:0]  size_m;
    logic        sign_m;
    logic        stall_m;
    logic [31:0] rdata_m;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_byteen;
    logic [31:0] dm_wdata;
    logic        dm_gnt, dm_rvalid;
    logic [31:0] dm_rdata;
    logic        adel_m, ades_m;

    int checks = 0;
    int errors = 0;

    m_dmem_ctrl #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .mem_rd_m(mem_rd_m), .mem_wr_m(mem_wr_m), .addr_m(addr_m), .wdata_m(wdata_m),
        .size_m(size_m), .sign_m(sign_m), .stall_m(stall_m), .rdata_m(rdata_m),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_byteen(dm_byteen),
        .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .adel_m(adel_m), .ades_m(ades_m)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd, wr;
        logic [31:0] addr, wd;
        logic [1:0]  sz;
        logic        sg;
        int          gd, rvd;
        logic [31:0] mw;
        int          e_stalls;
        logic        e_req;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        logic [31:0] e_rd;
    } vec_t;

    // observations of the latest access
    int          o_stalls;
    logic        o_req, o_stable, o_timeout, o_adel, o_ades, o_we;
    logic [31:0] o_addr, o_wd, o_rdata;
    logic [3:0]  o_be;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [1:0] sz, input logic sg,
                              input int gd, input int rvd, input logic [31:0] mw);
        int gw, rw;
        bit granted, rv_sent;
        @(negedge clk);
        mem_rd_m = rd; mem_wr_m = wr; addr_m = addr; wdata_m = wd; size_m = sz; sign_m = sg;
        o_stalls = 0; o_req = 0; o_stable = 1; o_timeout = 1; o_adel = 0; o_ades = 0;
        o_addr = 0; o_we = 0; o_be = 0; o_wd = 0; o_rdata = 0;
        gw = 0; rw = 0; granted = 0; rv_sent = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            #1;
            if (cyc == 0) begin
                o_adel = adel_m;
                o_ades = ades_m;
            end
            if (dm_req) begin
                if (!o_req) begin
                    o_req = 1; o_addr = dm_addr; o_we = dm_we; o_be = dm_byteen; o_wd = dm_wdata;
                end else if (dm_addr !== o_addr || dm_we !== o_we || dm_byteen !== o_be || dm_wdata !== o_wd) begin
                    o_stable = 0;
                end
            end
            if (!stall_m) begin
                o_rdata = rdata_m;
                o_timeout = 0;
                mem_rd_m = 0; mem_wr_m = 0;
                // stray response while the controller is finishing must be ignored
                if ($urandom_range(1, 0) == 1) begin
                    dm_rvalid = 1; dm_rdata = $urandom;
                end
                break;
            end
            o_stalls++;
            if (dm_req && !granted) begin
                if (gw == gd) begin
                    dm_gnt = 1; granted = 1;
                    if (!wr && rvd == 0) begin
                        dm_rvalid = 1; dm_rdata = mw; rv_sent = 1;
                    end
                end else begin
                    gw++;
                end
            end else if (granted && !wr && !rv_sent) begin
                rw++;
                if (rw == rvd) begin
                    dm_rvalid = 1; dm_rdata = mw; rv_sent = 1;
                end
            end
            @(negedge clk);
            dm_gnt = 0; dm_rvalid = 0;
        end
        @(negedge clk);
        dm_gnt = 0; dm_rvalid = 0; mem_rd_m = 0; mem_wr_m = 0;
        chk("timeout", o_timeout, 0);
        if (o_timeout) begin
            reset = 1;
            @(negedge clk);
            reset = 0;
        end
    endtask

    // Reference: byte-lane view of the access, independent of any state machine.
    function automatic void model(input logic [31:0] addr, input logic [31:0] wd, input logic [1:0] sz,
                                  input logic sg, input logic [31:0] mw, output logic mis,
                                  output logic [3:0] be, output logic [31:0] wdx, output logic [31:0] ld);
        int n, off;
        longint v;
        n = (sz == 2'b01) ? 2 : (sz == 2'b10) ? 1 : 4;
        off = (int'(addr % 4) / n) * n;
`ifdef MEM_EXC_EN
        mis = (int'(addr % 4) % n) != 0;
`else
        mis = 1'b0;
`endif
        be = 4'b0000;
        wdx = 32'h0;
        for (int k = 0; k < 4; k++) begin
            be[k] = (k >= off) && (k < off + n);
            wdx[8*k +: 8] = wd[8*(k % n) +: 8];
        end
        v = 0;
        for (int i = 0; i < n; i++) v = v | (longint'(mw[8*(off+i) +: 8]) << (8*i));
        if (sg && (((v >> (8*n-1)) & 1) == 1)) v = v - (64'sd1 <<< (8*n));
        ld = v[31:0];
    endfunction

    vec_t vecs[9];

    initial begin
        logic        mis, any_req;
        logic [3:0]  m_be;
        logic [31:0] m_wd, m_ld, last_rd;
        logic        rd, wr, sg;
        logic [31:0] addr, wd, mw;
        logic [1:0]  sz;
        int          gd, rvd, e_st;

        vecs[0] = '{1'b0, 1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 2'b00, 1'b0, 0, 0, 32'h0, 2, 1'b1, 32'h0000_1004, 4'b1111, 32'hDEAD_BEEF, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_2003, 32'h0000_00A5, 2'b10, 1'b0, 0, 0, 32'h0, 2, 1'b1, 32'h0000_2000, 4'b1000, 32'hA5A5_A5A5, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_3001, 32'h0, 2'b10, 1'b1, 0, 3, 32'h1234_8056, 5, 1'b1, 32'h0000_3000, 4'b0010, 32'h0, 32'hFFFF_FF80};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_3002, 32'h0, 2'b01, 1'b0, 0, 0, 32'h8001_7FFF, 2, 1'b1, 32'h0000_3000, 4'b1100, 32'h0, 32'h0000_8001};
        vecs[4] = '{1'b0, 1'b1, 32'h0000_4002, 32'h1234_ABCD, 2'b01, 1'b0, 2, 0, 32'h0, 4, 1'b1, 32'h0000_4000, 4'b1100, 32'hABCD_ABCD, 32'h0};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_5000, 32'h0, 2'b01, 1'b1, 1, 1, 32'h0000_8001, 4, 1'b1, 32'h0000_5000, 4'b0011, 32'h0, 32'hFFFF_8001};
        vecs[6] = '{1'b1, 1'b0, 32'h0000_6000, 32'h0, 2'b11, 1'b1, 0, 2, 32'hCAFE_F00D, 4, 1'b1, 32'h0000_6000, 4'b1111, 32'h0, 32'hCAFE_F00D};
        vecs[7] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0, 2'b00, 1'b0, 0, 0, 32'h0, 0, 1'b0, 32'h0, 4'b0000, 32'h0, 32'h0};
        vecs[8] = '{1'b1, 1'b0, 32'h0000_7003, 32'h0, 2'b10, 1'b0, 0, 0, 32'h9A00_0000, 2, 1'b1, 32'h0000_7000, 4'b1000, 32'h0, 32'h0000_009A};

        reset = 1; mem_rd_m = 0; mem_wr_m = 0; addr_m = 0; wdata_m = 0; size_m = 0; sign_m = 0;
        dm_gnt = 0; dm_rvalid = 1; dm_rdata = 32'hBAD0_BAD0;
        repeat (3) @(negedge clk);
        reset = 0;
        #1;
        chk("rst_req", dm_req, 0);
        chk("rst_we", dm_we, 0);
        chk("rst_addr", dm_addr, 0);
        chk("rst_byteen", dm_byteen, 0);
        chk("rst_wdata", dm_wdata, 0);
        chk("rst_rdata", rdata_m, 0);
        chk("rst_exc", {adel_m, ades_m}, 0);
        chk("rst_stall", stall_m, 0);
        @(negedge clk);
        dm_rvalid = 0;
        chk("stale_rvalid_ignored", rdata_m, 0);

        for (int i = 0; i < 9; i++) begin
            run_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].sz, vecs[i].sg,
                       vecs[i].gd, vecs[i].rvd, vecs[i].mw);
            chk($sformatf("v%0d_stalls", i), o_stalls, vecs[i].e_stalls);
            chk($sformatf("v%0d_req", i), o_req, vecs[i].e_req);
            if (vecs[i].e_req) begin
                chk($sformatf("v%0d_addr", i), o_addr, vecs[i].e_addr);
                chk($sformatf("v%0d_we", i), o_we, vecs[i].wr);
                chk($sformatf("v%0d_byteen", i), o_be, vecs[i].e_be);
                chk($sformatf("v%0d_wdata", i), o_wd, vecs[i].e_wd);
                chk($sformatf("v%0d_stable", i), o_stable, 1);
            end
            if (vecs[i].rd) chk($sformatf("v%0d_rdata", i), o_rdata, vecs[i].e_rd);
        end
        last_rd = 32'h0000_009A;

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(2, 0))
                0: begin rd = 1; wr = 0; end
                1: begin rd = 0; wr = 1; end
                default: begin rd = ($urandom_range(3, 0) == 0) ? 1'b0 : 1'b1; wr = 0; end
            endcase
            addr = {16'h0, 16'($urandom)};
            wd = $urandom; mw = $urandom;
            sz = 2'($urandom_range(3, 0)); sg = 1'($urandom_range(1, 0));
            gd = $urandom_range(3, 0); rvd = $urandom_range(3, 0);
            model(addr, wd, sz, sg, mw, mis, m_be, m_wd, m_ld);
            run_access(rd, wr, addr, wd, sz, sg, gd, rvd, mw);
            e_st = ((rd || wr) && !mis) ? (2 + gd + (rd ? rvd : 0)) : 0;
            chk("rnd_stalls", o_stalls, e_st);
            chk("rnd_req", o_req, (rd || wr) && !mis);
            chk("rnd_exc", {o_adel, o_ades}, {rd & mis, wr & mis});
            if ((rd || wr) && !mis) begin
                chk("rnd_addr", o_addr, addr & 32'hFFFF_FFFC);
                chk("rnd_we", o_we, wr);
                chk("rnd_byteen", o_be, m_be);
                if (wr) chk("rnd_wdata", o_wd, m_wd);
                chk("rnd_stable", o_stable, 1);
                if (rd) last_rd = m_ld;
            end
            chk("rnd_rdata", o_rdata, last_rd);
        end

        // reset while waiting for read data, then a late response
        @(negedge clk);
        mem_rd_m = 1; addr_m = 32'h0000_3000; size_m = 2'b00; sign_m = 0;
        any_req = 0;
        for (int c = 0; c < 20 && !any_req; c++) begin
            #1;
            if (dm_req) any_req = 1;
            else @(negedge clk);
        end
        chk("rstw_req_seen", any_req, 1);
        dm_gnt = 1;
        @(negedge clk);
        dm_gnt = 0;
        #1;
        chk("rstw_stall_in_wait", stall_m, 1);
        reset = 1;
        @(negedge clk);
        reset = 0; mem_rd_m = 0;
        #1;
        chk("rstw_req", dm_req, 0);
        chk("rstw_stall", stall_m, 0);
        chk("rstw_rdata", rdata_m, 0);
        dm_rvalid = 1; dm_rdata = 32'h5555_AAAA;
        @(negedge clk);
        dm_rvalid = 0;
        #1;
        chk("rstw_late_rvalid", rdata_m, 0);
        chk("rstw_req_after", dm_req, 0);

`ifdef MEM_EXC_EN
        @(negedge clk);
        mem_rd_m = 1; addr_m = 32'h0000_0002; size_m = 2'b00;
        #1;
        chk("exc_adel", adel_m, 1);
        chk("exc_ades", ades_m, 0);
        chk("exc_stall", stall_m, 0);
        any_req = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            if (dm_req) any_req = 1;
        end
        chk("exc_no_req", any_req, 0);
        mem_rd_m = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/m_dmem_ctrl.md
Name: m_dmem_ctrl

Overview:
- M-stage data-memory access controller. Consumes the memory request held in the EX/MEM pipeline register and drives a request/grant/response handshake to an external data memory.
- Holds the pipeline with `stall_m` until the access completes.
- Formats store byte-enables and data; extracts and sign/zero-extends load data for the MEM/WB register.

Parameters:
- ADDR_W, 32, byte-address width of `addr_m` and `dm_addr`.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous reset, active-high.
- mem_rd_m  in  1  M-stage load request.
- mem_wr_m  in  1  M-stage store request; never asserted together with `mem_rd_m`.
- addr_m  in  ADDR_W  byte address (ALU result).
- wdata_m  in  32  store data, right-aligned.
- size_m  in  2  access size: 00 word, 01 half, 10 byte, 11 treated as word.
- sign_m  in  1  1 means sign-extend the load, 0 means zero-extend.
- stall_m  out  1  freeze the PC, F, D, E and M registers; insert a bubble into W.
- rdata_m  out  32  formatted load result.
- dm_req  out  1  memory request valid.
- dm_we  out  1  write strobe for the request.
- dm_addr  out  ADDR_W  word-aligned address; bits [1:0] are always 0.
- dm_byteen  out  4  byte enables.
- dm_wdata  out  32  lane-replicated store data.
- dm_gnt  in  1  memory accepted the request.
- dm_rvalid  in  1  read data valid.
- dm_rdata  in  32  raw read word.
- adel_m  out  1  load address misaligned (only with MEM_EXC_EN).
- ades_m  out  1  store address misaligned (only with MEM_EXC_EN).

Behaviour:
- States: IDLE, REQ, WAIT, DONE. Reset forces IDLE.
- Reset values: `dm_req`=0, `dm_we`=0, `dm_addr`=0, `dm_byteen`=0, `dm_wdata`=0, `rdata_m`=0, `adel_m`=0, `ades_m`=0.
- `acc` = (`mem_rd_m` | `mem_wr_m`) & ~misaligned.
- `stall_m` = `acc` & (state != DONE), combinational.
- IDLE:
  - If `acc`: register `dm_addr`, `dm_we`, `dm_byteen` and `dm_wdata`; go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - `dm_req`=1; `dm_addr`, `dm_we`, `dm_byteen` and `dm_wdata` are held stable until `dm_gnt`.
  - `dm_gnt` with a store: go to DONE.
  - `dm_gnt` with a load and `dm_rvalid` in the same cycle: capture the data, go to DONE.
  - `dm_gnt` with a load and no `dm_rvalid`: go to WAIT.
  - `dm_req` drops in the cycle after `dm_gnt`.
- WAIT:
  - `dm_req`=0; wait for `dm_rvalid`, then capture the data and go to DONE.
  - No timeout.
- DONE:
  - `stall_m`=0 for exactly one cycle; the pipeline advances; next state is IDLE.
  - `rdata_m` is valid in DONE and holds until the next capture.
- Latency: a zero-wait memory gives 2 stall cycles per access (IDLE, REQ), then DONE.
- Store formatting:
  - word: `dm_byteen`=1111, `dm_wdata`=`wdata_m`.
  - half: `dm_byteen`=1100 if `addr[1]`, else 0011; `dm_wdata`={2{`wdata_m`[15:0]}}.
  - byte: `dm_byteen`=0001<<`addr[1:0]`; `dm_wdata`={4{`wdata_m`[7:0]}}.
- Load formatting: shift `dm_rdata` right by 8*`addr[1:0]`; take 8/16/32 bits per `size_m`; extend per `sign_m`. The address and size are latched in IDLE so that later changes to the M inputs do not affect the capture.
- Read byte-enables are the same as for stores; memory may ignore them.
- `dm_rvalid` in IDLE or DONE (including a stale response after reset) is ignored.
- Reset mid-operation (REQ or WAIT) returns to IDLE and drops `dm_req` the following cycle.
- `mem_rd_m`/`mem_wr_m` low in IDLE: no request is issued; `stall_m`=0.

Optional Feature:
- Macro: MEM_EXC_EN.
- Defined:
  - Misaligned means half with `addr[0]`=1, or word with `addr[1:0]`!=0.
  - A misaligned load asserts `adel_m` and a misaligned store asserts `ades_m`, combinationally, while the request is present in IDLE.
  - No memory request is issued and `stall_m`=0 for that access.
- Undefined:
  - `adel_m`/`ades_m` are tied to 0.
  - Misaligned addresses are never flagged; half accesses ignore `addr[0]`; word accesses ignore `addr[1:0]`.

Test Plan:
- Word store, `addr`=0x0000_1004, `wdata`=0xDEADBEEF, zero-wait memory -> `dm_addr`=0x1004, `dm_byteen`=1111, `dm_we`=1; `stall_m` high for 2 cycles, then low for 1 cycle.
- Byte store, `addr`=0x0000_2003, `wdata`=0x0000_00A5 -> `dm_byteen`=1000, `dm_wdata`=0xA5A5A5A5.
- Signed byte load, `addr`=0x0000_3001, `dm_rdata`=0x1234_8056, `dm_rvalid` 3 cycles after `dm_gnt` -> `rdata_m`=0xFFFF_FF80 in DONE; `stall_m` high for 5 cycles.
- Unsigned half load, `addr`=0x0000_3002, `dm_rdata`=0x8001_7FFF -> `rdata_m`=0x0000_8001.
- Reset asserted in WAIT, then `dm_rvalid` pulses after reset -> state IDLE, `dm_req`=0, `rdata_m`=0, response ignored.
- MEM_EXC_EN defined, word load at `addr`=0x0000_0002 -> `adel_m`=1, `dm_req` never asserted, `stall_m`=0.
